// File: rtl/piezo_req_sched_pkg.sv
// Purpose: shared types, tone half-period constants and tone lookup for the piezo scheduler.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package piezo_pkg;

  // Half-period counts for the tone datapath, one per note C..B.
  localparam logic [9:0] HALF_C = 10'd956;
  localparam logic [9:0] HALF_D = 10'd851;
  localparam logic [9:0] HALF_E = 10'd758;
  localparam logic [9:0] HALF_F = 10'd716;
  localparam logic [9:0] HALF_G = 10'd638;
  localparam logic [9:0] HALF_A = 10'd568;
  localparam logic [9:0] HALF_B = 10'd506;

  // 0 = rest, 1..7 = C..B
  typedef logic [2:0] tone_code_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [9:0] tone_lut(input tone_code_t code);
    case (code)
      3'd1:    return HALF_C;
      3'd2:    return HALF_D;
      3'd3:    return HALF_E;
      3'd4:    return HALF_F;
      3'd5:    return HALF_G;
      3'd6:    return HALF_A;
      3'd7:    return HALF_B;
      default: return 10'd0;
    endcase
  endfunction

endpackage

// File: rtl/piezo_tick_gen.sv
// Purpose: duration-tick prescaler; one-cycle tick every TICK_DIV clk cycles.
// Latency: first tick TICK_DIV cycles after clr drops.
// Backpressure: none; clr holds the count at zero and masks the tick.
// Ports: clk, rst (async active-high), clr (synchronous clear), tick (one-cycle pulse).
module piezo_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/piezo_req_sched.sv
// Purpose: fixed-priority, non-preemptive scheduler sharing the piezo tone datapath among 3 requesters.
// Latency: ack and tone_half 1 cycle after req is seen in IDLE; note lasts max(dur,1) ticks, then GAP_TICKS silent ticks.
// Backpressure: requests wait while busy or mute; mute aborts the current note without a done pulse.
// Ports: req/tone_code/dur per requester (index 0 highest priority), mute; ack/done one-cycle pulses,
//        busy, grant_id (last owner), tone_half (half-period count, 0 = silent).
module piezo_req_sched #(
  parameter int TICK_DIV  = 50000,
  parameter int GAP_TICKS = 20,
  parameter int NREQ      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     tone_code,
  input  logic [8*NREQ-1:0]     dur,
  input  logic                  mute,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [1:0]            grant_id,
  output logic [9:0]            tone_half
);
  import piezo_pkg::*;

  localparam logic [15:0] GAP_T = 16'(GAP_TICKS);

  state_t      state_q, state_d;
  logic        tick, tick_clr, last, any_req, grant_go;
  logic [1:0]  sel;
  logic [7:0]  dur_q, dur_tgt;
  logic [15:0] tcnt, tcnt_nxt;

  piezo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Lowest set index wins: descending loop, last write sticks.
  always_comb begin
    sel     = 2'd0;
    any_req = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) sel = 2'(i);
    end
  end

  // A zero duration still plays for one tick.
  assign dur_tgt  = (dur_q == 8'd0) ? 8'd1 : dur_q;
  assign tcnt_nxt = tcnt + 16'd1;

  always_comb begin
    last = 1'b0;
    if (state_q == PLAY) last = tick && (tcnt_nxt == {8'd0, dur_tgt});
    if (state_q == GAP)  last = tick && (tcnt_nxt == GAP_T);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; mute overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!mute && any_req) state_d = PLAY;
      PLAY: begin
        if (mute)      state_d = IDLE;
        else if (last) state_d = (GAP_TICKS == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (mute || last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    busy     = (state_q != IDLE);
    tick_clr = (state_q == IDLE);
    done     = '0;
    if (state_q == PLAY && last && !mute) done[grant_id] = 1'b1;
  end

  assign grant_go = (state_q == IDLE) && (state_d == PLAY);

  // Tick counter restarts on every state change so PLAY and GAP each count from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   tcnt <= '0;
    else if (state_d != state_q) tcnt <= '0;
    else if (tick)             tcnt <= tcnt_nxt;
  end

  // Grant registers; tone_half is loaded with the grant so it is live for the whole PLAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack       <= '0;
      grant_id  <= 2'd0;
      dur_q     <= 8'd0;
      tone_half <= 10'd0;
    end else begin
      ack <= '0;
      if (grant_go) begin
        ack       <= NREQ'(1) << sel;
        grant_id  <= sel;
        dur_q     <= dur[8*sel +: 8];
        tone_half <= tone_lut(tone_code[3*sel +: 3]);
      end else if (state_d != PLAY) begin
        tone_half <= 10'd0;
      end
    end
  end

endmodule

// File: tb/tb_piezo_req_sched.sv
// Purpose: self-checking bench for piezo_req_sched (TICK_DIV=10, GAP_TICKS=2, plus a GAP_TICKS=0 instance).
// Latency: expected ack/done cycles are predicted when stimulus is driven and checked as events occur.
// Backpressure: requesters drop req the cycle after their ack.
module tb_piezo_req_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       mute;
  logic [2:0] req, ack, done, req_n, ack_n, done_n;
  logic [8:0] tone_code, tone_code_n;
  logic [23:0] dur, dur_n;
  logic       busy, busy_n;
  logic [1:0] grant_id, grant_id_n;
  logic [9:0] tone_half, tone_half_n;

  always #5 clk = ~clk;

  piezo_req_sched #(.TICK_DIV(10), .GAP_TICKS(2), .NREQ(3)) dut (
    .clk(clk), .rst(rst), .req(req), .tone_code(tone_code), .dur(dur), .mute(mute),
    .ack(ack), .done(done), .busy(busy), .grant_id(grant_id), .tone_half(tone_half)
  );

  piezo_req_sched #(.TICK_DIV(10), .GAP_TICKS(0), .NREQ(3)) dut_ng (
    .clk(clk), .rst(rst), .req(req_n), .tone_code(tone_code_n), .dur(dur_n), .mute(mute),
    .ack(ack_n), .done(done_n), .busy(busy_n), .grant_id(grant_id_n), .tone_half(tone_half_n)
  );

  typedef struct {
    bit is_done;
    int id;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic push_ev(input bit is_done, input int id, input int c);
    ev_t e;
    e.is_done = is_done;
    e.id      = id;
    e.cyc     = c;
    exp_q.push_back(e);
  endtask

  // Advance one cycle, sample just after the edge, match ack/done events against the scoreboard.
  task automatic step();
    ev_t        e;
    logic [2:0] one;
    @(posedge clk);
    #1;
    cyc++;
    if (ack != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_event: got ack=%b at cycle %0d, required no event", ack, cyc);
      end else begin
        e   = exp_q.pop_front();
        one = 3'b001 << e.id;
        if (e.is_done || ack !== one || cyc != e.cyc) begin
          errors++;
          $display("FAIL ack_event: got ack=%b at cycle %0d, required %s id %0d at cycle %0d",
                   ack, cyc, e.is_done ? "done" : "ack", e.id, e.cyc);
        end
      end
    end
    if (done != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_event: got done=%b at cycle %0d, required no event", done, cyc);
      end else begin
        e   = exp_q.pop_front();
        one = 3'b001 << e.id;
        if (!e.is_done || done !== one || cyc != e.cyc) begin
          errors++;
          $display("FAIL done_event: got done=%b at cycle %0d, required %s id %0d at cycle %0d",
                   done, cyc, e.is_done ? "done" : "ack", e.id, e.cyc);
        end
      end
    end
    req   = req & ~ack;
    req_n = req_n & ~ack_n;
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d expected events never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_tone(input string name, input int j, input logic [9:0] exp_th);
    checks++;
    if (tone_half !== exp_th) begin
      errors++;
      $display("FAIL %s_tone: cycle +%0d got %0d, required %0d", name, j, tone_half, exp_th);
    end
  endtask

  task automatic check_busy(input string name, input int j, input logic exp_b);
    checks++;
    if (busy !== exp_b) begin
      errors++;
      $display("FAIL %s_busy: cycle +%0d got %b, required %b", name, j, busy, exp_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mute = 1'b0;
    req = '0; tone_code = '0; dur = '0;
    req_n = '0; tone_code_n = '0; dur_n = '0;
    repeat (3) step();
    checks++; if (ack !== 3'b000)      begin errors++; $display("FAIL reset_ack: got %b, required 000", ack); end
    checks++; if (done !== 3'b000)     begin errors++; $display("FAIL reset_done: got %b, required 000", done); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (grant_id !== 2'd0)   begin errors++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
    checks++; if (tone_half !== 10'd0) begin errors++; $display("FAIL reset_tone_half: got %0d, required 0", tone_half); end
    checks++; if (busy_n !== 1'b0)     begin errors++; $display("FAIL reset_busy_ng: got %b, required 0", busy_n); end
    checks++; if (tone_half_n !== 10'd0) begin errors++; $display("FAIL reset_tone_ng: got %0d, required 0", tone_half_n); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int c0;
    c0 = cyc;
    tone_code[8:6] = 3'd5; dur[23:16] = 8'd3; req[2] = 1'b1;
    push_ev(0, 2, c0 + 1);
    push_ev(1, 2, c0 + 30);
    for (int j = 1; j <= 55; j++) begin
      step();
      check_tone("single", j, (j <= 30) ? 10'd638 : 10'd0);
      check_busy("single", j, j <= 50);
      if (j == 1) begin
        checks++;
        if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d, required 2", grant_id); end
      end
    end
    check_drained("single");
  endtask

  task automatic test_priority();
    int c0;
    c0 = cyc;
    tone_code[2:0] = 3'd1; dur[7:0] = 8'd1;
    tone_code[5:3] = 3'd2; dur[15:8] = 8'd1;
    req[1:0] = 2'b11;
    push_ev(0, 0, c0 + 1);
    push_ev(1, 0, c0 + 10);
    push_ev(0, 1, c0 + 32);
    push_ev(1, 1, c0 + 41);
    for (int j = 1; j <= 65; j++) begin
      step();
      check_tone("priority", j, (j <= 10) ? 10'd956 : (j >= 32 && j <= 41) ? 10'd851 : 10'd0);
      if (j == 1) begin
        checks++;
        if (grant_id !== 2'd0) begin errors++; $display("FAIL priority_grant0: got %0d, required 0", grant_id); end
      end
      if (j == 32) begin
        checks++;
        if (grant_id !== 2'd1) begin errors++; $display("FAIL priority_grant1: got %0d, required 1", grant_id); end
      end
    end
    check_drained("priority");
  endtask

  task automatic test_nonpreempt();
    int c0;
    c0 = cyc;
    tone_code[8:6] = 3'd1; dur[23:16] = 8'd2; req[2] = 1'b1;
    push_ev(0, 2, c0 + 1);
    push_ev(1, 2, c0 + 20);
    push_ev(0, 0, c0 + 42);
    push_ev(1, 0, c0 + 51);
    for (int j = 1; j <= 75; j++) begin
      step();
      if (j == 5) begin
        tone_code[2:0] = 3'd3; dur[7:0] = 8'd1; req[0] = 1'b1;
      end
      check_tone("nonpreempt", j, (j <= 20) ? 10'd956 : (j >= 42 && j <= 51) ? 10'd758 : 10'd0);
    end
    check_drained("nonpreempt");
  endtask

  task automatic test_boundaries();
    int c0;
    c0 = cyc;
    tone_code[5:3] = 3'd0; dur[15:8] = 8'd0; req[1] = 1'b1;
    push_ev(0, 1, c0 + 1);
    push_ev(1, 1, c0 + 10);
    for (int j = 1; j <= 35; j++) begin
      step();
      check_tone("rest_dur0", j, 10'd0);
      check_busy("rest_dur0", j, j <= 30);
    end
    check_drained("rest_dur0");
  endtask

  task automatic test_no_gap();
    logic [2:0] exp_a, exp_d;
    logic [9:0] exp_th;
    tone_code_n[2:0] = 3'd7; dur_n[7:0] = 8'd1; req_n[0] = 1'b1;
    for (int j = 1; j <= 24; j++) begin
      step();
      if (j == 3) begin
        tone_code_n[5:3] = 3'd4; dur_n[15:8] = 8'd1; req_n[1] = 1'b1;
      end
      exp_a  = (j == 1) ? 3'b001 : (j == 12) ? 3'b010 : 3'b000;
      exp_d  = (j == 10) ? 3'b001 : (j == 21) ? 3'b010 : 3'b000;
      exp_th = (j <= 10) ? 10'd506 : (j >= 12 && j <= 21) ? 10'd716 : 10'd0;
      checks++;
      if (ack_n !== exp_a) begin errors++; $display("FAIL nogap_ack: cycle +%0d got %b, required %b", j, ack_n, exp_a); end
      checks++;
      if (done_n !== exp_d) begin errors++; $display("FAIL nogap_done: cycle +%0d got %b, required %b", j, done_n, exp_d); end
      checks++;
      if (tone_half_n !== exp_th) begin errors++; $display("FAIL nogap_tone: cycle +%0d got %0d, required %0d", j, tone_half_n, exp_th); end
    end
  endtask

  task automatic test_mute();
    int c0;
    c0 = cyc;
    tone_code[2:0] = 3'd4; dur[7:0] = 8'd3; req[0] = 1'b1;
    push_ev(0, 0, c0 + 1);
    push_ev(0, 1, c0 + 16);
    push_ev(1, 1, c0 + 25);
    for (int j = 1; j <= 50; j++) begin
      step();
      if (j == 5) mute = 1'b1;
      if (j == 6) begin
        tone_code[5:3] = 3'd6; dur[15:8] = 8'd1; req[1] = 1'b1;
      end
      if (j == 15) mute = 1'b0;
      check_tone("mute", j, (j <= 5) ? 10'd716 : (j >= 16 && j <= 25) ? 10'd568 : 10'd0);
      check_busy("mute", j, (j <= 5) || (j >= 16 && j <= 45));
    end
    check_drained("mute");
  endtask

  task automatic test_async_rst();
    int c1;
    tone_code[8:6] = 3'd2; dur[23:16] = 8'd2; req[2] = 1'b1;
    push_ev(0, 2, cyc + 1);
    repeat (4) step();
    check_tone("arst_pre", 4, 10'd851);
    #3 rst = 1'b1;
    #1;
    checks++; if (tone_half !== 10'd0) begin errors++; $display("FAIL arst_tone: got %0d, required 0", tone_half); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL arst_busy: got %b, required 0", busy); end
    checks++; if (grant_id !== 2'd0)   begin errors++; $display("FAIL arst_grant_id: got %0d, required 0", grant_id); end
    checks++; if (done !== 3'b000)     begin errors++; $display("FAIL arst_done: got %b, required 000", done); end
    step();
    step();
    #3 rst = 1'b0;
    step();
    check_drained("arst_first");
    c1 = cyc;
    tone_code[8:6] = 3'd3; dur[23:16] = 8'd1; req[2] = 1'b1;
    push_ev(0, 2, c1 + 1);
    push_ev(1, 2, c1 + 10);
    for (int j = 1; j <= 32; j++) begin
      step();
      check_tone("arst_after", j, (j <= 10) ? 10'd758 : 10'd0);
    end
    check_drained("arst_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_nonpreempt();
    test_boundaries();
    test_no_gap();
    test_mute();
    test_async_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
